mddr_tx_sequencer: RTL and testbench
====================================

// Module: mddr_tx_sequencer
// PURPOSE
//  Core-side write sequencer for the MDDR memory-I/O pad ring. Buffers write
//  beats, then drives the single-ended DQ pads (I/OEN) and the differential
//  DQS pad (I/OEN) with preamble, toggling strobe and postamble. Also drives
//  the pads' input-path powerdown (PWD) when the interface is idle.
//  Sits between the memory-controller write path and the pad instances.
// PARAMETERS
//  DQ_W       8   data pads driven per beat
//  BURST_LEN  4   beats per burst (>=2)
//  FIFO_DEPTH 8   beat buffer depth (power of 2, >=2*BURST_LEN)
//  PRE_CYC    1   DQS preamble cycles (>=1)
//  POST_CYC   1   DQS postamble cycles (>=1)
//  PWD_IDLE   16  idle cycles before pad_pwd asserts (>=1)
// PORTS
//  clk       in   1     core clock, all logic rising-edge
//  rst_n     in   1     synchronous active-low reset
//  s_valid   in   1     write beat valid
//  s_ready   out  1     beat accepted when s_valid&s_ready
//  s_data    in   DQ_W  write beat data
//  dq_i      out  DQ_W  to DQ pad I
//  dq_oen    out  1     to all DQ pad OEN (1 = tristate)
//  dqs_i     out  1     to DQS differential pad I
//  dqs_oen   out  1     to DQS pad OEN (1 = tristate)
//  pad_pwd   out  1     to DQ/DQS pad PWD (1 = receiver off)
//  busy      out  1     FSM not IDLE
// BEHAVIOUR
//  Reset (rst_n=0 at edge, any state): FIFO emptied, FSM->IDLE, counters 0;
//   dq_i=0, dq_oen=1, dqs_i=0, dqs_oen=1, pad_pwd=0, busy=0, s_ready=0 while low.
//  All pad outputs registered; no combinational path from s_* to pads.
//  FIFO: s_ready = !full (registered count). Push on s_valid&s_ready;
//   s_valid ignored when full. Pop only in DATA, exactly one per cycle.
//  FSM:
//   IDLE: oen both 1, dqs_i=0. If count>=BURST_LEN -> PREAMBLE.
//   PREAMBLE (PRE_CYC cyc): dqs_oen=0, dqs_i=0, dq_oen=1 -> DATA.
//   DATA (BURST_LEN cyc): dq_oen=0, dqs_oen=0, dq_i=popped beat,
//    dqs_i=1 on first beat, inverted each subsequent beat.
//    Last beat: if (count-1)>=BURST_LEN (same-cycle push not counted) stay
//    in DATA, beat counter restarts, dqs keeps toggling (seamless burst);
//    else -> POSTAMBLE.
//   POSTAMBLE (POST_CYC cyc): dqs_oen=0, dqs_i=0, dq_oen=1, dq_i holds
//    -> IDLE (next burst needs fresh preamble, even if FIFO refilled).
//  Latency: count reaches BURST_LEN at edge N -> preamble on pads from N+1,
//   first data beat on dq_i from N+1+PRE_CYC.
//  Beat order preserved; FIFO pointers wrap modulo FIFO_DEPTH.
//  pad_pwd: idle counter counts consecutive IDLE cycles with FIFO empty,
//   saturating at PWD_IDLE; pad_pwd=1 when counter==PWD_IDLE. Any push or
//   leaving IDLE clears counter and pad_pwd in the next cycle.
//  Simultaneous push+pop: count unchanged. Full FIFO + pop: s_ready
//   reasserts next cycle.
// TESTING (defaults unless noted)
//  Reset: rst_n=0 2 cyc -> dq_oen=1, dqs_oen=1, busy=0, s_ready=1 after release.
//  Single burst: push A0,A1,A2,A3 back-to-back -> 1 preamble cyc (dqs_oen=0,
//   dqs_i=0), dq_i=A0..A3 with dqs_i=1,0,1,0, 1 postamble cyc, then IDLE.
//  Seamless: push 8 beats continuously -> one preamble, 8 data cyc, dqs_i
//   1,0,1,0,1,0,1,0, single postamble; no oen gap.
//  Backpressure: push 9 beats with FSM held by 3 beats pre-loaded -> s_ready=0
//   while count==8, no beat lost or duplicated across 3 bursts.
//  Powerdown: idle 16 cyc -> pad_pwd=1; push one beat -> pad_pwd=0 next cyc.
//  Mid-burst reset: rst_n=0 on 2nd data beat -> next edge all oen=1, FIFO
//   empty; fresh 4-beat burst afterwards transmits correctly.

Source files
------------

// File: rtl/mddr_tx_sequencer_if.sv
// Write-beat handshake and pad-drive bundle of the MDDR write sequencer.
// The master side is the memory-controller write path and the pad observer.
// The slave side is the sequencer itself.
interface mddr_tx_sequencer_if #(
    parameter int DQ_W = 8
);
    logic            s_valid;
    logic            s_ready;
    logic [DQ_W-1:0] s_data;
    logic [DQ_W-1:0] dq_i;
    logic            dq_oen;
    logic            dqs_i;
    logic            dqs_oen;
    logic            pad_pwd;
    logic            busy;

    modport master (
        output s_valid, s_data,
        input  s_ready, dq_i, dq_oen, dqs_i, dqs_oen, pad_pwd, busy
    );

    modport slave (
        input  s_valid, s_data,
        output s_ready, dq_i, dq_oen, dqs_i, dqs_oen, pad_pwd, busy
    );
endinterface

// File: rtl/mddr_tx_sequencer.sv
// MDDR core-side write sequencer.
// Buffers write beats, then drives the DQ and DQS pads through
// preamble, toggling strobe, and postamble phases.
// Powers down the pad receivers after a run of empty idle cycles.
module mddr_tx_sequencer #(
    parameter int DQ_W       = 8,
    parameter int BURST_LEN  = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int PRE_CYC    = 1,
    parameter int POST_CYC   = 1,
    parameter int PWD_IDLE   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mddr_tx_sequencer_if.slave   bus
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int MAX_A   = (BURST_LEN > PRE_CYC) ? BURST_LEN : PRE_CYC;
    localparam int CYC_MAX = (MAX_A > POST_CYC) ? MAX_A : POST_CYC;
    localparam int CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
    localparam int IDLE_W  = $clog2(PWD_IDLE + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_DATA = 2'd2,
        ST_POST = 2'd3
    } state_t;

    logic [DQ_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    state_t            state_q;
    logic [CYC_W-1:0]  cyc_q;
    logic [DQ_W-1:0]   dq_q;
    logic              dq_oen_q, dqs_q, dqs_oen_q;
    logic [IDLE_W-1:0] idle_q;
    logic              pwd_q;

    logic              s_ready;
    logic              push, pop;
    logic [PTR_W-1:0]  head_sel;

    assign s_ready = rst_n && (count_q != CNT_W'(FIFO_DEPTH));
    assign push    = bus.s_valid && s_ready;
    assign pop     = (state_q == ST_DATA);
    // The beat shown in a DATA cycle is popped at that cycle's closing edge,
    // so the next beat to load sits one past the head while popping.
    assign head_sel = pop ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    assign count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

    // Beat storage write port; contents need no reset, pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= bus.s_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // Burst FSM with registered pad drives.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cyc_q     <= '0;
            dq_q      <= '0;
            dq_oen_q  <= 1'b1;
            dqs_q     <= 1'b0;
            dqs_oen_q <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (count_q >= CNT_W'(BURST_LEN)) begin
                        state_q   <= ST_PRE;
                        cyc_q     <= '0;
                        dqs_oen_q <= 1'b0;
                        dqs_q     <= 1'b0;
                    end
                end
                ST_PRE: begin
                    if (cyc_q == CYC_W'(PRE_CYC - 1)) begin
                        state_q  <= ST_DATA;
                        cyc_q    <= '0;
                        dq_oen_q <= 1'b0;
                        dqs_q    <= 1'b1;
                        dq_q     <= mem[head_sel];
                    end else begin
                        cyc_q <= cyc_q + CYC_W'(1);
                    end
                end
                ST_DATA: begin
                    if (cyc_q == CYC_W'(BURST_LEN - 1)) begin
                        // count_q still includes the beat on the pads now.
                        if (count_q > CNT_W'(BURST_LEN)) begin
                            cyc_q <= '0;
                            dq_q  <= mem[head_sel];
                            dqs_q <= ~dqs_q;
                        end else begin
                            state_q  <= ST_POST;
                            cyc_q    <= '0;
                            dq_oen_q <= 1'b1;
                            dqs_q    <= 1'b0;
                        end
                    end else begin
                        cyc_q <= cyc_q + CYC_W'(1);
                        dq_q  <= mem[head_sel];
                        dqs_q <= ~dqs_q;
                    end
                end
                ST_POST: begin
                    if (cyc_q == CYC_W'(POST_CYC - 1)) begin
                        state_q   <= ST_IDLE;
                        cyc_q     <= '0;
                        dqs_oen_q <= 1'b1;
                    end else begin
                        cyc_q <= cyc_q + CYC_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Idle run counter driving the pad receiver powerdown.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idle_q <= '0;
            pwd_q  <= 1'b0;
        end else if (push || (state_q != ST_IDLE) || (count_q != '0)) begin
            idle_q <= '0;
            pwd_q  <= 1'b0;
        end else if (idle_q != IDLE_W'(PWD_IDLE)) begin
            idle_q <= idle_q + IDLE_W'(1);
            pwd_q  <= (idle_q == IDLE_W'(PWD_IDLE - 1));
        end
    end

    assign bus.s_ready = s_ready;
    assign bus.dq_i    = dq_q;
    assign bus.dq_oen  = dq_oen_q;
    assign bus.dqs_i   = dqs_q;
    assign bus.dqs_oen = dqs_oen_q;
    assign bus.pad_pwd = pwd_q;
    assign bus.busy    = (state_q != ST_IDLE);
endmodule

// File: tb/tb_mddr_tx_sequencer.sv
// Self-checking bench for mddr_tx_sequencer: vector table, directed
// sequences, randomized traffic against a schedule-based reference model,
// and a backpressure run on a long-preamble instance.
module tb_mddr_tx_sequencer;
    localparam int DQ_W       = 8;
    localparam int BURST_LEN  = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int PRE_CYC    = 1;
    localparam int POST_CYC   = 1;
    localparam int PWD_IDLE   = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mddr_tx_sequencer_if #(.DQ_W(DQ_W)) bus();
    mddr_tx_sequencer_if #(.DQ_W(DQ_W)) bp();

    mddr_tx_sequencer #(
        .DQ_W(DQ_W), .BURST_LEN(BURST_LEN), .FIFO_DEPTH(FIFO_DEPTH),
        .PRE_CYC(PRE_CYC), .POST_CYC(POST_CYC), .PWD_IDLE(PWD_IDLE)
    ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    mddr_tx_sequencer #(
        .DQ_W(DQ_W), .BURST_LEN(BURST_LEN), .FIFO_DEPTH(FIFO_DEPTH),
        .PRE_CYC(3), .POST_CYC(2), .PWD_IDLE(PWD_IDLE)
    ) dut_bp (.clk(clk), .rst_n(rst_n), .bus(bp));

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    endtask

    // Reference model: a queue of buffered beats plus a plan of upcoming
    // pad cycles, appended whole-phase at a time when a burst is launched.
    typedef struct packed {
        logic [7:0] dq;
        logic dq_oen, dqs, dqs_oen, is_data, is_last, busy;
    } slot_t;

    logic [7:0] m_beats[$];
    slot_t      m_plan[$];
    slot_t      m_cur;
    int         m_idle;
    logic       m_pwd;
    logic       m_rn;

    function automatic slot_t mk(logic dq_oen, logic dqs_oen, logic is_data, logic is_last, logic busy);
        slot_t s;
        s = '{dq: 8'h00, dq_oen: dq_oen, dqs: 1'b0, dqs_oen: dqs_oen,
              is_data: is_data, is_last: is_last, busy: busy};
        return s;
    endfunction

    task automatic plan_burst(input bit with_pre);
        if (with_pre) for (int i = 0; i < PRE_CYC; i++) m_plan.push_back(mk(1, 0, 0, 0, 1));
        for (int i = 0; i < BURST_LEN; i++) m_plan.push_back(mk(0, 0, 1, i == BURST_LEN - 1, 1));
    endtask

    task automatic model_edge(input logic rn, input logic v, input logic [7:0] d);
        int cnt;
        bit push;
        slot_t nxt;
        m_rn = rn;
        if (!rn) begin
            m_beats.delete();
            m_plan.delete();
            m_cur  = mk(1, 1, 0, 0, 0);
            m_idle = 0;
            m_pwd  = 1'b0;
            return;
        end
        cnt  = m_beats.size();
        push = v && (cnt < FIFO_DEPTH);
        if (push || m_cur.busy || cnt != 0) m_idle = 0;
        else if (m_idle < PWD_IDLE) m_idle++;
        m_pwd = (m_idle == PWD_IDLE);
        if (m_plan.size() == 0) begin
            if (m_cur.is_data && m_cur.is_last) begin
                if (cnt - 1 >= BURST_LEN) plan_burst(0);
                else for (int i = 0; i < POST_CYC; i++) m_plan.push_back(mk(1, 0, 0, 0, 1));
            end else if (!m_cur.busy && cnt >= BURST_LEN) begin
                plan_burst(1);
            end
        end
        if (m_cur.is_data) void'(m_beats.pop_front());
        if (push) m_beats.push_back(d);
        if (m_plan.size() != 0) nxt = m_plan.pop_front();
        else nxt = mk(1, 1, 0, 0, 0);
        if (nxt.is_data) begin
            nxt.dq  = m_beats[0];
            nxt.dqs = m_cur.is_data ? ~m_cur.dqs : 1'b1;
        end else begin
            nxt.dq = m_cur.dq;
        end
        m_cur = nxt;
    endtask

    task automatic check_model();
        chk("dq_i",    bus.dq_i,    m_cur.dq);
        chk("dq_oen",  bus.dq_oen,  m_cur.dq_oen);
        chk("dqs_i",   bus.dqs_i,   m_cur.dqs);
        chk("dqs_oen", bus.dqs_oen, m_cur.dqs_oen);
        chk("busy",    bus.busy,    m_cur.busy);
        chk("pad_pwd", bus.pad_pwd, m_pwd);
        chk("s_ready", bus.s_ready, m_rn && (m_beats.size() < FIFO_DEPTH));
    endtask

    task automatic step(input logic rn, input logic v, input logic [7:0] d);
        rst_n       = rn;
        bus.s_valid = v;
        bus.s_data  = d;
        @(posedge clk);
        #1;
        model_edge(rn, v, d);
        check_model();
    endtask

    typedef struct {
        logic rn, v;
        logic [7:0] d, e_dq;
        logic e_dq_oen, e_dqs, e_dqs_oen, e_busy, e_rdy;
    } vec_t;
    vec_t tv[14];

    // Backpressure instance driver with handshake monitor and scoreboard.
    logic [7:0] bp_exp[$];
    int  bp_sent;
    bit  bp_saw_full;

    task automatic bp_cycle(input logic v, input logic [7:0] d, output bit acc);
        bp.s_valid = v;
        bp.s_data  = d;
        acc = v && bp.s_ready;
        if (v && !bp.s_ready) bp_saw_full = 1'b1;
        @(posedge clk);
        #1;
        if (acc) bp_exp.push_back(d);
        if (!bp.dq_oen) begin
            if (bp_exp.size() == 0) chk("bp_extra_beat", bp.dq_i, 32'hFFFF_FFFF);
            else chk("bp_beat", bp.dq_i, bp_exp.pop_front());
            bp_sent++;
        end
    endtask

    initial begin
        logic [7:0] got[8];
        logic [7:0] pat;
        int n_data, n_dqs_on, n_runs;
        logic prev_oen;
        int pct;
        bit acc;
        int n_acc;
        logic [7:0] dd;

        rst_n = 1'b0;
        bus.s_valid = 1'b0; bus.s_data = '0;
        bp.s_valid  = 1'b0; bp.s_data  = '0;
        m_cur = mk(1, 1, 0, 0, 0); m_idle = 0; m_pwd = 0; m_rn = 0;

        // rn v d | dq oen dqs dqs_oen busy rdy
        tv[0]  = '{0, 0, 8'h00, 8'h00, 1, 0, 1, 0, 0};
        tv[1]  = '{0, 0, 8'h00, 8'h00, 1, 0, 1, 0, 0};
        tv[2]  = '{1, 1, 8'hA0, 8'h00, 1, 0, 1, 0, 1};
        tv[3]  = '{1, 1, 8'hA1, 8'h00, 1, 0, 1, 0, 1};
        tv[4]  = '{1, 1, 8'hA2, 8'h00, 1, 0, 1, 0, 1};
        tv[5]  = '{1, 1, 8'hA3, 8'h00, 1, 0, 1, 0, 1};
        tv[6]  = '{1, 0, 8'h00, 8'h00, 1, 0, 0, 1, 1};
        tv[7]  = '{1, 0, 8'h00, 8'hA0, 0, 1, 0, 1, 1};
        tv[8]  = '{1, 0, 8'h00, 8'hA1, 0, 0, 0, 1, 1};
        tv[9]  = '{1, 0, 8'h00, 8'hA2, 0, 1, 0, 1, 1};
        tv[10] = '{1, 0, 8'h00, 8'hA3, 0, 0, 0, 1, 1};
        tv[11] = '{1, 0, 8'h00, 8'hA3, 1, 0, 0, 1, 1};
        tv[12] = '{1, 0, 8'h00, 8'hA3, 1, 0, 1, 0, 1};
        tv[13] = '{1, 0, 8'h00, 8'hA3, 1, 0, 1, 0, 1};
        for (int i = 0; i < 14; i++) begin
            step(tv[i].rn, tv[i].v, tv[i].d);
            chk($sformatf("tv%0d_dq_i", i),    bus.dq_i,    tv[i].e_dq);
            chk($sformatf("tv%0d_dq_oen", i),  bus.dq_oen,  tv[i].e_dq_oen);
            chk($sformatf("tv%0d_dqs_i", i),   bus.dqs_i,   tv[i].e_dqs);
            chk($sformatf("tv%0d_dqs_oen", i), bus.dqs_oen, tv[i].e_dqs_oen);
            chk($sformatf("tv%0d_busy", i),    bus.busy,    tv[i].e_busy);
            chk($sformatf("tv%0d_s_ready", i), bus.s_ready, tv[i].e_rdy);
        end

        // Seamless: 8 beats pushed back-to-back form one continuous transfer.
        n_data = 0; n_dqs_on = 0; n_runs = 0; pat = '0; prev_oen = 1'b1;
        for (int c = 0; c < 40; c++) begin
            dd = 8'hB0 + 8'(c);
            step(1, c < 8, dd);
            if (!bus.dq_oen) begin
                if (n_data < 8) got[n_data] = bus.dq_i;
                pat = {pat[6:0], bus.dqs_i};
                n_data++;
            end
            if (!bus.dqs_oen) n_dqs_on++;
            if (!bus.dq_oen && prev_oen) n_runs++;
            prev_oen = bus.dq_oen;
        end
        chk("seam_beats", n_data, 8);
        chk("seam_dqs_pattern", pat, 8'hAA);
        chk("seam_dqs_oen_cycles", n_dqs_on, 10);
        chk("seam_dq_oen_runs", n_runs, 1);
        for (int i = 0; i < 8; i++) chk($sformatf("seam_data%0d", i), got[i], 8'hB0 + 8'(i));

        // Powerdown after 16 empty idle cycles, cleared by a push.
        step(0, 0, 0);
        step(0, 0, 0);
        for (int c = 0; c < 15; c++) step(1, 0, 0);
        chk("pwd_before_16", bus.pad_pwd, 0);
        step(1, 0, 0);
        chk("pwd_at_16", bus.pad_pwd, 1);
        step(1, 1, 8'hC0);
        chk("pwd_clear_on_push", bus.pad_pwd, 0);

        // Mid-burst reset on the second data beat.
        step(1, 1, 8'hC1);
        step(1, 1, 8'hC2);
        step(1, 1, 8'hC3);
        step(1, 0, 0);
        chk("mid_pre", bus.dqs_oen, 0);
        step(1, 0, 0);
        chk("mid_beat0", bus.dq_i, 8'hC0);
        step(1, 0, 0);
        chk("mid_beat1", bus.dq_i, 8'hC1);
        step(0, 0, 0);
        chk("mid_rst_dq_oen", bus.dq_oen, 1);
        chk("mid_rst_dqs_oen", bus.dqs_oen, 1);
        chk("mid_rst_busy", bus.busy, 0);
        n_data = 0;
        for (int c = 0; c < 14; c++) begin
            dd = 8'hD0 + 8'(c);
            step(1, c < 4, dd);
            if (!bus.dq_oen) begin
                if (n_data < 8) got[n_data] = bus.dq_i;
                n_data++;
            end
        end
        chk("post_rst_beats", n_data, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("post_rst_data%0d", i), got[i], 8'hD0 + 8'(i));

        // Randomized traffic with varying load and occasional reset.
        for (int seg = 0; seg < 6; seg++) begin
            pct = $urandom_range(10, 100);
            for (int c = 0; c < 250; c++) begin
                step($urandom_range(0, 299) != 0, $urandom_range(0, 99) < pct, 8'($urandom));
            end
        end

        // Backpressure on the long-preamble instance: 3 pre-loaded beats,
        // then 9 more offered continuously; 12 beats across 3 bursts.
        rst_n = 1'b1;
        bus.s_valid = 1'b0;
        bp_sent = 0; bp_saw_full = 1'b0;
        for (int c = 0; c < 3; c++) bp_cycle(1, 8'hE0 + 8'(c), acc);
        for (int c = 0; c < 3; c++) bp_cycle(0, 0, acc);
        n_acc = 0;
        for (int c = 0; c < 60 && n_acc < 9; c++) begin
            dd = 8'hF0 + 8'(n_acc);
            bp_cycle(1, dd, acc);
            if (acc) n_acc++;
        end
        chk("bp_accepted", n_acc, 9);
        for (int c = 0; c < 80 && (bp_exp.size() != 0 || bp.busy); c++) bp_cycle(0, 0, acc);
        chk("bp_sent", bp_sent, 12);
        chk("bp_left", bp_exp.size(), 0);
        chk("bp_saw_backpressure", bp_saw_full, 1);
        chk("bp_ready_after_drain", bp.s_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
